clk_div_ctrl: RTL

//   Run-time controller and sequencer for the integer clock divider path.

---
 rtl/clk_div_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// Run-time integer clock divider: owns the divide ratio, emits a flop-driven
// divided clock and period-start tick, and swaps ratio/enable only at period boundaries.
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_en,
  output logic             clk_q,
  output logic             tick,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] cur_div, div_nx;
  logic [CNT_W-1:0] pend_div, pend_div_nx;
  logic             pend_en, pend_en_nx;
  logic             err_nx;
  logic             xfer, legal, at_end;

  assign cfg_ready = (state != DRAIN);
  assign busy      = (state == DRAIN);
  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = (cfg_div >= TWO);
  assign at_end    = (cnt == cur_div - ONE);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    div_nx      = cur_div;
    pend_div_nx = pend_div;
    pend_en_nx  = pend_en;
    err_nx      = 1'b0;
    case (state)
      OFF: begin
        if (xfer && !legal) begin
          err_nx = 1'b1;
        end else if (xfer) begin
          div_nx = cfg_div;
          cnt_nx = '0;
          if (cfg_en) state_nx = RUN;
        end
      end
      RUN: begin
        cnt_nx = at_end ? '0 : cnt + ONE;
        // A request landing on the last count still waits a full old period.
        if (xfer && !legal) begin
          err_nx = 1'b1;
        end else if (xfer) begin
          pend_div_nx = cfg_div;
          pend_en_nx  = cfg_en;
          state_nx    = DRAIN;
        end
      end
      DRAIN: begin
        if (at_end) begin
          cnt_nx   = '0;
          div_nx   = pend_div;
          state_nx = pend_en ? RUN : OFF;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: begin
        state_nx = OFF;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so clk_q is a clean flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= OFF;
      cur_div <= DEF_VAL;
      cnt     <= '0;
      clk_q   <= 1'b0;
      tick    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      cur_div <= div_nx;
      cnt     <= cnt_nx;
      clk_q   <= (state_nx != OFF) && (cnt_nx < (div_nx >> 1));
      tick    <= (state_nx != OFF) && (cnt_nx == '0);
      err     <= err_nx;
    end
  end

  always_ff @(posedge clk) begin
    pend_div <= pend_div_nx;
    pend_en  <= pend_en_nx;
  end

endmodule
